// File: rtl/calc_display_decoder.sv
// calc_display_decoder: sign-magnitude result capture, double-dabble BCD conversion, 6-position 7-seg scan
//   clk        system clock
//   RST        asynchronous active-high reset
//   value_in   16-bit sign-magnitude value (bit 15 sign), captured on load in IDLE
//   load       single-cycle conversion request
//   busy       high while shifting (15 cycles)
//   done       one-cycle pulse, bcd_out/sign_out already hold the new result
//   sign_out   registered sign of the last converted value (negative zero reads as 0)
//   bcd_out    registered five BCD digits, [19:16] ten-thousands .. [3:0] units
//   digit_sel  registered one-hot position enable, bit 0 units .. bit 4 ten-thousands, bit 5 sign
//   seg        active-high segments gfedcba for the selected position
//   Optional: define CALC_DISP_BLANK_EN for leading-zero blanking of positions 1-4.
module calc_display_decoder #(
   parameter int SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [15:0] value_in,
   input  logic        load,
   output logic        busy,
   output logic        done,
   output logic        sign_out,
   output logic [19:0] bcd_out,
   output logic [5:0]  digit_sel,
   output logic [6:0]  seg
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [6:0] SEG_LUT [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111,
      7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
   };
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [19:0]     scr_q, scr_d, adj;
   logic [14:0]     mag_q, mag_d;
   logic            sgn_q, sgn_d;
   logic [19:0]     bcd_q, bcd_d;
   logic            sign_q, sign_d;
   logic [CW-1:0]   scan_q, scan_d;
   logic [2:0]      pos_q, pos_d;
   logic [5:0]      sel_q, sel_d;
   logic            wrap, blank;
   logic [3:0]      nib;
   always_comb begin
      adj = scr_q;
      for (int i = 0; i < 5; i++)
         adj[4*i +: 4] = scr_q[4*i +: 4] >= 4'd5 ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
   end
   // The final shift writes its result straight into bcd_out so that the
   // registered digits are already valid during the cycle done is high.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      scr_d   = scr_q;
      mag_d   = mag_q;
      sgn_d   = sgn_q;
      bcd_d   = bcd_q;
      sign_d  = sign_q;
      if (state_q == IDLE && load) begin
         state_d = SHIFT;
         cnt_d   = 4'd0;
         scr_d   = 20'd0;
         mag_d   = value_in[14:0];
         sgn_d   = value_in[15] & |value_in[14:0];
      end else if (state_q == SHIFT) begin
         {scr_d, mag_d} = {adj, mag_q} << 1;
         cnt_d          = cnt_q + 4'd1;
         if (cnt_q == 4'd14) begin
            state_d = DONE;
            bcd_d   = scr_d;
            sign_d  = sgn_q;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_comb begin
      wrap  = scan_q == CW'(SCAN_DIV - 1);
      scan_d = wrap ? '0 : scan_q + 1'b1;
      pos_d  = wrap ? (pos_q == 3'd5 ? 3'd0 : pos_q + 3'd1) : pos_q;
      sel_d  = 6'b1 << pos_d;
   end
   always_comb begin
      nib = 4'(bcd_q >> {pos_q, 2'b00});
`ifdef CALC_DISP_BLANK_EN
      blank = pos_q != 3'd0 && (bcd_q >> {pos_q, 2'b00}) == 20'd0;
`else
      blank = 1'b0;
`endif
      seg = pos_q == 3'd5 ? {sign_q, 6'b0} : blank ? 7'b0 : SEG_LUT[nib];
   end
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         scr_q   <= 20'd0;
         mag_q   <= 15'd0;
         sgn_q   <= 1'b0;
         bcd_q   <= 20'd0;
         sign_q  <= 1'b0;
         scan_q  <= '0;
         pos_q   <= 3'd0;
         sel_q   <= 6'b000001;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         scr_q   <= scr_d;
         mag_q   <= mag_d;
         sgn_q   <= sgn_d;
         bcd_q   <= bcd_d;
         sign_q  <= sign_d;
         scan_q  <= scan_d;
         pos_q   <= pos_d;
         sel_q   <= sel_d;
      end
   end
   assign busy      = state_q == SHIFT;
   assign done      = state_q == DONE;
   assign sign_out  = sign_q;
   assign bcd_out   = bcd_q;
   assign digit_sel = sel_q;
endmodule

// File: tb/tb_calc_display_decoder.sv
// tb_calc_display_decoder: randomized and directed checks of calc_display_decoder against a decimal-arithmetic model
module tb_calc_display_decoder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value_in = 16'd0;
   logic        busy_a, done_a, sign_a, busy_b, done_b, sign_b;
   logic [19:0] bcd_a, bcd_b;
   logic [5:0]  sel_a, sel_b;
   logic [6:0]  seg_a, seg_b;
   int checks = 0;
   int failures = 0;
   int phase = 0, ticks = 0, cap_mag = 0, res_val = 0;
   bit cap_sign = 0, res_sign = 0;
   localparam int DA = 4;
   localparam int DB = 2;
   localparam logic [6:0] SEGS [10] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
   };
   localparam int P10 [6] = '{1, 10, 100, 1000, 10000, 100000};
   always #5 clk = ~clk;
   calc_display_decoder #(.SCAN_DIV(DA)) dut_a (
      .clk(clk), .RST(rst), .value_in(value_in), .load(load), .busy(busy_a), .done(done_a),
      .sign_out(sign_a), .bcd_out(bcd_a), .digit_sel(sel_a), .seg(seg_a));
   calc_display_decoder #(.SCAN_DIV(DB)) dut_b (
      .clk(clk), .RST(rst), .value_in(value_in), .load(load), .busy(busy_b), .done(done_b),
      .sign_out(sign_b), .bcd_out(bcd_b), .digit_sel(sel_b), .seg(seg_b));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [19:0] bcd_of(input int v);
      logic [19:0] r = 20'd0;
      for (int i = 0; i < 5; i++) r[4*i +: 4] = 4'((v / P10[i]) % 10);
      return r;
   endfunction
   function automatic logic [6:0] exp_seg(input int d, input int t, input int v, input bit s);
      int p = (t / d) % 6;
      if (p == 5) return s ? 7'b1000000 : 7'b0000000;
`ifdef CALC_DISP_BLANK_EN
      if (p > 0 && v < P10[p]) return 7'b0000000;
`endif
      return SEGS[(v / P10[p]) % 10];
   endfunction
   initial forever begin
      @(posedge clk);
      if (rst) begin
         phase = 0; ticks = 0; res_val = 0; res_sign = 0;
      end else begin
         ticks++;
         if (phase == 0 && load) begin
            phase = 1; cap_mag = int'(value_in[14:0]); cap_sign = value_in[15];
         end else if (phase >= 1 && phase <= 15) begin
            phase++;
            if (phase == 16) begin
               res_val = cap_mag; res_sign = cap_sign && cap_mag != 0;
            end
         end else if (phase == 16) phase = 0;
      end
      #1;
      chk("busy", 32'(busy_a), 32'(phase >= 1 && phase <= 15));
      chk("done", 32'(done_a), 32'(phase == 16));
      chk("bcd", 32'(bcd_a), 32'(bcd_of(res_val)));
      chk("sign", 32'(sign_a), 32'(res_sign));
      chk("sel_a", 32'(sel_a), 32'(6'b1 << ((ticks / DA) % 6)));
      chk("seg_a", 32'(seg_a), 32'(exp_seg(DA, ticks, res_val, res_sign)));
      chk("bcd_b", 32'(bcd_b), 32'(bcd_of(res_val)));
      chk("sel_b", 32'(sel_b), 32'(6'b1 << ((ticks / DB) % 6)));
      chk("seg_b", 32'(seg_b), 32'(exp_seg(DB, ticks, res_val, res_sign)));
   end
   task automatic pulse(input logic [15:0] v);
      @(negedge clk); value_in = v; load = 1'b1;
      @(negedge clk); load = 1'b0;
   endtask
   task automatic convert(input logic [15:0] v);
      pulse(v);
      repeat (20) @(negedge clk);
   endtask
   initial begin
      int n, d_at, t;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_sel", 32'(sel_a), 32'h01);
      chk("rst_seg", 32'(seg_a), 32'h3f);
      chk("rst_busy", 32'(busy_a), 32'h0);
      pulse(16'h000C);
      n = 0; d_at = -1;
      for (int c = 0; c < 20; c++) begin
         if (busy_a) n++;
         if (done_a) d_at = c;
         @(negedge clk);
      end
      chk("busy_len", 32'(n), 32'd15);
      chk("done_at", 32'(d_at), 32'd15);
      chk("lit_12", 32'(bcd_a), 32'h00012);
      chk("lit_12_sign", 32'(sign_a), 32'h0);
      convert(16'hFFFF);
      chk("lit_neg_max", 32'(bcd_a), 32'h32767);
      chk("lit_neg_max_sign", 32'(sign_a), 32'h1);
      convert(16'h7FF9);
      chk("lit_32761", 32'(bcd_a), 32'h32761);
      convert(16'h8000);
      chk("lit_negzero", 32'(bcd_a), 32'h0);
      chk("lit_negzero_sign", 32'(sign_a), 32'h0);
      convert(16'h0000);
      chk("lit_zero", 32'(bcd_a), 32'h0);
      pulse(16'h0004);
      repeat (2) @(negedge clk);
      value_in = 16'h0063; load = 1'b1;
      @(negedge clk); load = 1'b0;
      repeat (11) @(negedge clk);
      load = 1'b1;
      @(negedge clk); load = 1'b0;
      repeat (5) @(negedge clk);
      chk("lit_ignore", 32'(bcd_a), 32'h00004);
      pulse(16'h1234);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy_a), 32'h0);
      chk("abort_bcd", 32'(bcd_a), 32'h0);
      chk("abort_sel", 32'(sel_a), 32'h01);
      @(negedge clk); rst = 1'b0;
      n = 0;
      repeat (20) begin @(negedge clk); if (done_a) n++; end
      chk("abort_no_done", 32'(n), 32'h0);
      convert(16'h0005);
      chk("lit_5", 32'(bcd_a), 32'h00005);
      t = 0;
      while (sel_a !== 6'b000010 && t < 50) begin @(negedge clk); t++; end
      chk("wait_pos1", 32'(t < 50), 32'h1);
`ifdef CALC_DISP_BLANK_EN
      chk("lit_pos1_seg", 32'(seg_a), 32'h00);
`else
      chk("lit_pos1_seg", 32'(seg_a), 32'h3f);
`endif
      t = 0;
      while (sel_a === 6'b000010 && t < 50) begin @(negedge clk); t++; end
      chk("lit_dwell", 32'(t), 32'd4);
      chk("lit_pos2_sel", 32'(sel_a), 32'h04);
      t = 0;
      while (sel_a !== 6'b000001 && t < 50) begin @(negedge clk); t++; end
      chk("lit_pos0_seg", 32'(seg_a), 32'h6d);
      convert(16'h8009);
      t = 0;
      while (sel_b !== 6'b100000 && t < 50) begin @(negedge clk); t++; end
      chk("lit_minus", 32'(seg_b), 32'h40);
      t = 0;
      while (sel_b !== 6'b000001 && t < 50) begin @(negedge clk); t++; end
      chk("lit_nine", 32'(seg_b), 32'h6f);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         value_in = 16'($urandom);
         load = $urandom_range(0, 5) == 0;
         rst = $urandom_range(0, 299) == 0;
      end
      @(negedge clk); load = 1'b0; rst = 1'b0;
      repeat (30) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
